// File: rtl/raytracing_collector_pkg.sv
// Shared types and sizing for the raytracing line collector and its pixel sequencer.
// Also holds the line-y squaring helper handed to the workers.
package raytracing_collector_pkg;

    localparam int N_WORKERS        = 10;
    localparam int JOBS_SUBDIVISION = 64;
    localparam int PX_X_B           = 10;
    localparam int PX_Y_B           = 10;
    localparam int PX_Y_SQRD_B      = 16;

    typedef logic [11:0] Color;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RENDER = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } collector_state_e;

    // Square via the magnitude so the result is exact and unsigned for |y| <= 255.
    function automatic logic [PX_Y_SQRD_B-1:0] square_y(input logic signed [PX_Y_B-1:0] y);
        logic [PX_Y_B-1:0]   mag;
        logic [2*PX_Y_B-1:0] prod;
        mag  = y[PX_Y_B-1] ? PX_Y_B'(-y) : PX_Y_B'(y);
        prod = mag * mag;
        return prod[PX_Y_SQRD_B-1:0];
    endfunction

endpackage

// File: rtl/raytracing_collector_pixel_sequencer.sv
// Walks worker w / entry j in pixel order (x = w + N_WORKERS*j) and presents
// one registered pixel at a time on a valid/ready stream.
module raytracing_pixel_sequencer
    import raytracing_collector_pkg::*;
#(
    parameter int N_WORKERS        = raytracing_collector_pkg::N_WORKERS,
    parameter int JOBS_SUBDIVISION = raytracing_collector_pkg::JOBS_SUBDIVISION
) (
    input  logic                                       clk,
    input  logic                                       rst_,
    input  logic                                       start_i,
    input  logic signed [PX_Y_B-1:0]                   line_y_i,
    input  Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] buffers_i,
    input  logic                                       pix_ready_i,
    output logic                                       pix_valid_o,
    output logic [PX_X_B-1:0]                          pix_x_o,
    output logic signed [PX_Y_B-1:0]                   pix_y_o,
    output Color                                       pix_color_o,
    output logic                                       last_xfer_o
);

    localparam int WW     = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int JW     = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
    localparam int X_LAST = N_WORKERS * JOBS_SUBDIVISION - 1;

    logic                     running_q, running_d;
    logic [WW-1:0]            w_q, w_d;
    logic [JW-1:0]            j_q, j_d;
    logic                     valid_q, valid_d;
    logic [PX_X_B-1:0]        x_q, x_d;
    logic signed [PX_Y_B-1:0] y_q, y_d;
    Color                     color_q, color_d;
    logic                     xfer_s, last_s, load_s;

    // Next-pixel selection: load on start or after each non-final transfer.
    always_comb begin
        xfer_s    = valid_q & pix_ready_i;
        last_s    = xfer_s & (x_q == PX_X_B'(X_LAST));
        load_s    = (start_i & ~running_q) | (xfer_s & ~last_s);
        running_d = running_q;
        w_d       = w_q;
        j_d       = j_q;
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        if (load_s) begin
            running_d = 1'b1;
            valid_d   = 1'b1;
            color_d   = buffers_i[w_q][j_q];
            if (running_q) begin
                x_d = x_q + PX_X_B'(1);
            end else begin
                x_d = {PX_X_B{1'b0}};
                y_d = line_y_i;
            end
            if (w_q == WW'(N_WORKERS - 1)) begin
                w_d = {WW{1'b0}};
                j_d = j_q + JW'(1);
            end else begin
                w_d = w_q + WW'(1);
                j_d = j_q;
            end
        end else if (last_s) begin
            running_d = 1'b0;
            valid_d   = 1'b0;
            w_d       = {WW{1'b0}};
            j_d       = {JW{1'b0}};
        end else begin
            valid_d = valid_q;
        end
    end

    // Counter and output register slice.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            running_q <= 1'b0;
            w_q       <= {WW{1'b0}};
            j_q       <= {JW{1'b0}};
            valid_q   <= 1'b0;
            x_q       <= {PX_X_B{1'b0}};
            y_q       <= {PX_Y_B{1'b0}};
            color_q   <= 12'h000;
        end else begin
            running_q <= running_d;
            w_q       <= w_d;
            j_q       <= j_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
        end
    end

    assign pix_valid_o = valid_q;
    assign pix_x_o     = x_q;
    assign pix_y_o     = y_q;
    assign pix_color_o = color_q;
    assign last_xfer_o = last_s;

endmodule

// File: rtl/raytracing_collector.sv
// Line controller: arms the raytracing workers for one line, waits for them to
// finish, then drains their buffers as an ordered 640-pixel stream.
module raytracing_collector
    import raytracing_collector_pkg::*;
#(
    parameter int N_WORKERS        = raytracing_collector_pkg::N_WORKERS,
    parameter int JOBS_SUBDIVISION = raytracing_collector_pkg::JOBS_SUBDIVISION
) (
    input  logic                                       clk,
    input  logic                                       rst_,
    input  logic                                       line_start,
    input  logic signed [PX_Y_B-1:0]                   line_y,
    output logic                                       busy,
    output logic                                       worker_activate,
    output logic signed [PX_Y_B-1:0]                   worker_pixel_y,
    output logic [PX_Y_SQRD_B-1:0]                     worker_pixel_y_sqrd,
    input  logic [N_WORKERS-1:0]                       worker_busy,
    input  Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] worker_buffers,
    output logic                                       pix_valid,
    input  logic                                       pix_ready,
    output logic [PX_X_B-1:0]                          pix_x,
    output logic signed [PX_Y_B-1:0]                   pix_y,
    output Color                                       pix_color,
    output logic                                       line_done
);

    collector_state_e         state_q;
    logic                     busy_q;
    logic                     activate_q;
    logic                     done_q;
    logic signed [PX_Y_B-1:0] y_q;
    logic [PX_Y_SQRD_B-1:0]   ysq_q;
    logic                     last_xfer_s;

    // Line FSM; DONE also accepts a new line so back-to-back lines lose no cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            activate_q <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= {PX_Y_B{1'b0}};
            ysq_q      <= {PX_Y_SQRD_B{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (line_start) begin
                        y_q        <= line_y;
                        ysq_q      <= square_y(line_y);
                        busy_q     <= 1'b1;
                        activate_q <= 1'b1;
                        state_q    <= ST_ARM;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (&worker_busy) begin
                        state_q <= ST_RENDER;
                    end
                end
                ST_RENDER: begin
                    if (worker_busy == {N_WORKERS{1'b0}}) begin
                        activate_q <= 1'b0;
                        state_q    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_xfer_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q     <= 1'b0;
                    activate_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    raytracing_pixel_sequencer #(
        .N_WORKERS       (N_WORKERS),
        .JOBS_SUBDIVISION(JOBS_SUBDIVISION)
    ) u_sequencer (
        .clk        (clk),
        .rst_       (rst_),
        .start_i    (state_q == ST_DRAIN),
        .line_y_i   (y_q),
        .buffers_i  (worker_buffers),
        .pix_ready_i(pix_ready),
        .pix_valid_o(pix_valid),
        .pix_x_o    (pix_x),
        .pix_y_o    (pix_y),
        .pix_color_o(pix_color),
        .last_xfer_o(last_xfer_s)
    );

    assign busy                = busy_q;
    assign worker_activate     = activate_q;
    assign worker_pixel_y      = y_q;
    assign worker_pixel_y_sqrd = ysq_q;
    assign line_done           = done_q;

endmodule

// File: tb/tb_raytracing_collector.sv
// Directed bench for raytracing_collector with behavioural worker models that
// stay busy for 100+w cycles once activated.
module tb_raytracing_collector;
    import raytracing_collector_pkg::*;

    localparam int NW            = 10;
    localparam int JS            = 64;
    localparam int RENDER_BASE   = 100;
    localparam int FIRST_VALID_N = RENDER_BASE + (NW - 1) + 4;

    logic                   clk;
    logic                   rst_;
    logic                   line_start;
    logic signed [9:0]      line_y;
    logic                   busy;
    logic                   worker_activate;
    logic signed [9:0]      worker_pixel_y;
    logic [15:0]            worker_pixel_y_sqrd;
    logic [NW-1:0]          worker_busy;
    Color [NW-1:0][JS-1:0]  bufs;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [9:0]             pix_x;
    logic signed [9:0]      pix_y;
    Color                   pix_color;
    logic                   line_done;

    logic [NW-1:0]          wdone;
    int                     wcnt [NW];
    int                     checks_total = 0;
    int                     fail_count   = 0;

    raytracing_collector #(.N_WORKERS(NW), .JOBS_SUBDIVISION(JS)) dut (
        .clk                (clk),
        .rst_               (rst_),
        .line_start         (line_start),
        .line_y             (line_y),
        .busy               (busy),
        .worker_activate    (worker_activate),
        .worker_pixel_y     (worker_pixel_y),
        .worker_pixel_y_sqrd(worker_pixel_y_sqrd),
        .worker_busy        (worker_busy),
        .worker_buffers     (bufs),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_x              (pix_x),
        .pix_y              (pix_y),
        .pix_color          (pix_color),
        .line_done          (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Worker w: busy for RENDER_BASE+w cycles after activate, READY again once activate drops.
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (!worker_activate) begin
                worker_busy[w] <= 1'b0;
                wdone[w]       <= 1'b0;
                wcnt[w]        <= 0;
            end else if (!worker_busy[w] && !wdone[w]) begin
                worker_busy[w] <= 1'b1;
                wcnt[w]        <= RENDER_BASE + w;
            end else if (worker_busy[w]) begin
                if (wcnt[w] == 1) begin
                    worker_busy[w] <= 1'b0;
                    wdone[w]       <= 1'b1;
                end
                wcnt[w] <= wcnt[w] - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_color(input int x);
        return 12'((x % NW) * JS + x / NW);
    endfunction

    task automatic run_line(input int y, input int ready_pct, input bit poke, input int abort_x);
        int   n;
        int   exp_x;
        bit   fin;
        bit   seen_valid;
        bit   stalled;
        bit   poked_drain;
        logic [9:0]  held_x;
        logic [11:0] held_c;
        n = 0; exp_x = 0; fin = 1'b0; seen_valid = 1'b0; stalled = 1'b0; poked_drain = 1'b0;
        held_x = 10'd0; held_c = 12'h000;
        line_y     = 10'(y);
        line_start = 1'b1;
        while (!fin && n < 4000) begin
            @(negedge clk);
            n++;
            line_start = 1'b0;
            if (n == 1) begin
                check_eq("busy_after_start", busy, 1);
                check_eq("activate_arm", worker_activate, 1);
                check_eq("worker_y", int'(worker_pixel_y), y);
                check_eq("worker_y_sqrd", worker_pixel_y_sqrd, y * y);
                check_eq("done_one_cycle", line_done, 0);
            end
            if (stalled) begin
                check_eq("hold_valid", pix_valid, 1);
                check_eq("hold_x", pix_x, held_x);
                check_eq("hold_color", pix_color, held_c);
            end
            if (abort_x >= 0 && exp_x == abort_x) begin
                rst_ = 1'b0;
                #1;
                check_eq("abort_valid", pix_valid, 0);
                check_eq("abort_activate", worker_activate, 0);
                check_eq("abort_busy", busy, 0);
                fin = 1'b1;
                break;
            end
            if (line_done) begin
                check_eq("done_after_last", exp_x, 640);
                check_eq("busy_at_done", busy, 0);
                check_eq("valid_at_done", pix_valid, 0);
                fin = 1'b1;
                break;
            end
            if (poke && n == 50) begin
                check_eq("activate_render", worker_activate, 1);
                line_y     = 10'sd99;
                line_start = 1'b1;
            end
            if (poke && exp_x == 100 && !poked_drain) begin
                poked_drain = 1'b1;
                line_y      = -10'sd77;
                line_start  = 1'b1;
            end
            pix_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (pix_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check_eq("first_valid_latency", n, FIRST_VALID_N);
                    check_eq("activate_dropped", worker_activate, 0);
                    check_eq("drain_worker_y", int'(worker_pixel_y), y);
                    check_eq("drain_worker_sqrd", worker_pixel_y_sqrd, y * y);
                end
                if (pix_ready) begin
                    check_eq("pix_x", pix_x, exp_x);
                    check_eq("pix_color", pix_color, exp_color(exp_x));
                    check_eq("pix_y", int'(pix_y), y);
                    if (exp_x == 639) check_eq("color_639", pix_color, 12'h27F);
                    exp_x++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_x  = pix_x;
                    held_c  = pix_color;
                end
            end else begin
                stalled = 1'b0;
            end
        end
        check_eq("line_finished", fin, 1);
    endtask

    task automatic idle_watch(input int cycles);
        int stray;
        int busy_seen;
        stray = 0; busy_seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (line_done) stray++;
            if (busy || pix_valid) busy_seen++;
        end
        check_eq("stray_done", stray, 0);
        check_eq("idle_quiet", busy_seen, 0);
    endtask

    initial begin
        rst_       = 1'b0;
        line_start = 1'b0;
        line_y     = 10'sd0;
        pix_ready  = 1'b0;
        for (int w = 0; w < NW; w++)
            for (int j = 0; j < JS; j++)
                bufs[w][j] = 12'(w * 64 + j);
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_activate", worker_activate, 0);
        check_eq("rst_valid", pix_valid, 0);
        check_eq("rst_done", line_done, 0);
        check_eq("rst_pix_x", pix_x, 0);
        check_eq("rst_pix_y", pix_y, 0);
        check_eq("rst_color", pix_color, 0);
        check_eq("rst_wy", worker_pixel_y, 0);
        check_eq("rst_wy_sqrd", worker_pixel_y_sqrd, 0);
        rst_ = 1'b1;
        @(negedge clk);

        run_line(-5, 100, 1'b0, -1);
        run_line(17, 50, 1'b0, -1);
        run_line(-100, 100, 1'b1, -1);
        idle_watch(20);

        run_line(33, 100, 1'b0, 300);
        repeat (3) @(negedge clk);
        check_eq("in_reset_valid", pix_valid, 0);
        rst_ = 1'b1;
        idle_watch(5);

        run_line(240, 100, 1'b0, -1);
        run_line(-240, 100, 1'b0, -1);
        run_line(240, 100, 1'b0, -1);
        idle_watch(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks_total, fail_count);
        $finish;
    end

endmodule
